sample_scheduler: RTL
=====================

Name: sample_scheduler

Overview:
- Generates the synth's audio sample-rate tick from the system clock with a run-time programmable divisor.
- On each tick, sequences NUM_VOICES voice slots, one at a time, through the shared voice datapath (oscillator/envelope/mixer) using a valid/ready handshake.
- Signals frame completion to the mixer/DAC path.
- Flags overruns when the datapath cannot finish all voices within one sample period.

Parameters:
- CLK_DIVISOR, 1133, reset-time divisor (system clock Hz / sample rate Hz; 50 MHz / 44.1 kHz).
- NUM_VOICES, 8, number of voice slots per sample frame (≥1).
- VOICE_W, 3, width of voice index; must satisfy 2^VOICE_W ≥ NUM_VOICES.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = tick generation runs; 0 = divider held, no new frames.
- div_load  input  1  one-cycle pulse; capture div_value as pending divisor.
- div_value  input  32  new divisor value.
- voice_ready  input  1  datapath accepts the current voice slot.
- overrun_clr  input  1  clears the overrun flag.
- sample_tick  output  1  one-cycle pulse at sample rate.
- voice_valid  output  1  voice slot request to the datapath.
- voice_idx  output  VOICE_W  index of the requested voice.
- frame_done  output  1  one-cycle pulse after the last voice is accepted.
- busy  output  1  frame in progress (state ≠ IDLE).
- overrun  output  1  sticky: a tick arrived while busy.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counter 0.
  - div_reg = CLK_DIVISOR; pending-load flag cleared.
- Divider:
  - 32-bit counter increments each cycle while enable = 1.
  - When counter == div_reg − 1: sample_tick = 1 for that cycle and counter wraps to 0 on the next edge.
  - Tick period = div_reg cycles exactly.
  - enable = 0: counter forced to 0, no ticks. A frame already in progress still completes.
- Divisor load:
  - div_load captures div_value into div_pending and sets the pending flag. A later load before application overwrites the earlier one.
  - The pending divisor is applied to div_reg on the wrap cycle (the tick cycle), or immediately when enable = 0.
  - Values < 2 are clamped to 2.
  - The current period is never truncated.
- Frame FSM, states IDLE → RUN → DONE → IDLE:
  - IDLE: on sample_tick, go to RUN with voice_idx = 0.
  - RUN: voice_valid = 1. A transfer occurs when voice_valid & voice_ready.
    - After a transfer with voice_idx < NUM_VOICES − 1: voice_idx increments.
    - After a transfer with voice_idx = NUM_VOICES − 1: go to DONE.
    - voice_idx is stable while voice_valid = 1 and voice_ready = 0.
  - DONE: frame_done = 1 for one cycle, voice_valid = 0; then return to IDLE.
  - voice_valid never depends combinationally on voice_ready.
- Latency:
  - Tick in cycle T → voice_valid = 1, voice_idx = 0 in cycle T+1.
  - With voice_ready held high: voices 0..N−1 are accepted in cycles T+1..T+N, and frame_done fires in cycle T+N+1.
- Overrun:
  - A sample_tick while state ≠ IDLE (RUN or DONE) is dropped; no frame is queued.
  - The dropped tick sets overrun.
  - overrun_clr clears the flag. If overrun_clr and a new overrun occur in the same cycle, set wins.
- busy = 1 in RUN and DONE.
- Reset mid-frame: the FSM returns to IDLE immediately, voice_valid drops the next cycle, and no frame_done is generated.
- voice_idx holds its last value in IDLE. It is don't-care when voice_valid = 0.

Test Plan:
1. CLK_DIVISOR=10, NUM_VOICES=4, enable=1, voice_ready=1 → sample_tick at cycles 9, 19, 29 after reset release; voice_idx 0,1,2,3 accepted in cycles 10–13; frame_done at cycle 14; overrun stays 0.
2. Backpressure: voice_ready=0 for 3 cycles while voice_idx=1 → voice_valid stays 1 and voice_idx stays 1; frame_done delayed by 3 cycles.
3. Divisor change: div_load with div_value=6 at cycle 12 → next tick still at 19, following ticks at 25 and 31; div_value=1 is clamped to give period 2.
4. Overrun: voice_ready=0 held for 15 cycles → the tick at 19 is dropped while busy and overrun=1. overrun_clr asserted in the same cycle as a new overrun leaves overrun=1; overrun_clr alone clears it.
5. enable=0 during RUN → the frame completes with frame_done, counter reads 0, no further ticks. Re-enable → first tick 10 cycles later.
6. reset asserted while voice_idx=2 in RUN → next cycle: voice_valid=0, busy=0, overrun=0, no frame_done, div_reg back to CLK_DIVISOR.

Source files
------------

// File: rtl/sample_scheduler_if.sv
// Voice-slot handshake between the sample scheduler and the shared voice datapath.
interface sample_scheduler_if #(
    parameter int unsigned VOICE_W = 3
);
    logic               voice_valid;
    logic [VOICE_W-1:0] voice_idx;
    logic               voice_ready;
    logic               frame_done;

    modport master (
        output voice_valid,
        output voice_idx,
        output frame_done,
        input  voice_ready
    );

    modport slave (
        input  voice_valid,
        input  voice_idx,
        input  frame_done,
        output voice_ready
    );
endinterface

// File: rtl/sample_scheduler.sv
// Sample-rate tick generator with programmable divisor, plus a frame sequencer
// that walks every voice slot through the shared datapath once per tick.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for sample_tick; voice_idx holds its last value
// RUN    | voice_valid high, offering voice_idx to the datapath
// DONE   | one-cycle frame_done pulse, then back to IDLE
module sample_scheduler #(
    parameter int unsigned CLK_DIVISOR = 1133,
    parameter int unsigned NUM_VOICES  = 8,
    parameter int unsigned VOICE_W     = 3
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               enable,
    input  logic               div_load,
    input  logic [31:0]        div_value,
    input  logic               overrun_clr,
    output logic               sample_tick,
    output logic               busy,
    output logic               overrun,
    sample_scheduler_if.master voice_if
);

    localparam logic [31:0]        DIV_RESET = (CLK_DIVISOR < 2) ? 32'd2 : 32'(CLK_DIVISOR);
    localparam logic [VOICE_W-1:0] LAST_IDX  = VOICE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        counter;
    logic [31:0]        div_reg;
    logic [31:0]        div_pending;
    logic               div_pend_flag;
    logic [31:0]        div_value_clamped;
    logic               wrap;
    logic               voice_valid_q;
    logic [VOICE_W-1:0] voice_idx_q;
    logic               frame_done_q;

    // A divisor below 2 would give a tick every cycle or none at all.
    assign div_value_clamped = (div_value < 32'd2) ? 32'd2 : div_value;
    assign wrap              = (counter == div_reg - 32'd1);
    assign sample_tick       = enable & ~reset & wrap;

    assign voice_if.voice_valid = voice_valid_q;
    assign voice_if.voice_idx   = voice_idx_q;
    assign voice_if.frame_done  = frame_done_q;

    // Divider counter: counts up while enabled, wraps on the tick cycle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            counter <= '0;
        end else if (!enable || wrap) begin
            counter <= '0;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    // Divisor register: new values only land on a wrap so a period is never cut short.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_reg       <= DIV_RESET;
            div_pending   <= DIV_RESET;
            div_pend_flag <= 1'b0;
        end else if (!enable) begin
            if (div_load) begin
                div_reg <= div_value_clamped;
            end else if (div_pend_flag) begin
                div_reg <= div_pending;
            end
            div_pend_flag <= 1'b0;
        end else begin
            if (wrap && div_pend_flag) begin
                div_reg       <= div_pending;
                div_pend_flag <= 1'b0;
            end
            if (div_load) begin
                div_pending   <= div_value_clamped;
                div_pend_flag <= 1'b1;
            end
        end
    end

    // Frame FSM with registered handshake outputs and sticky overrun flag.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state         <= S_IDLE;
            voice_valid_q <= 1'b0;
            voice_idx_q   <= '0;
            frame_done_q  <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            // A tick that arrives mid-frame is dropped, not queued.
            if (sample_tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (sample_tick) begin
                        state         <= S_RUN;
                        voice_valid_q <= 1'b1;
                        voice_idx_q   <= '0;
                        busy          <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (voice_if.voice_ready) begin
                        if (voice_idx_q == LAST_IDX) begin
                            state         <= S_DONE;
                            voice_valid_q <= 1'b0;
                            frame_done_q  <= 1'b1;
                        end else begin
                            voice_idx_q <= voice_idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    frame_done_q <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    voice_valid_q <= 1'b0;
                    frame_done_q  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
